// File: rtl/aud_dac_serializer_if.sv
// Parallel-sample side of the WM8731 DAC serializer: AudDSP handshake, codec LR clock and serial output.
interface aud_dac_serializer_if #(
  parameter int DATA_W = 16
);
  logic              i_en;
  logic              i_daclrck;
  logic [DATA_W-1:0] i_dac_data;
  logic              o_aud_dacdat;
  logic              o_sent_finish;
  logic              o_busy;
  logic              o_truncated;

  modport master (
    output i_en, i_daclrck, i_dac_data,
    input  o_aud_dacdat, o_sent_finish, o_busy, o_truncated
  );

  modport slave (
    input  i_en, i_daclrck, i_dac_data,
    output o_aud_dacdat, o_sent_finish, o_busy, o_truncated
  );
endinterface

// File: rtl/aud_dac_serializer.sv
// Shifts one parallel sample MSB-first onto WM8731 DACDAT per qualifying DACLRCK edge (I2S or left-justified).
module aud_dac_serializer #(
  parameter int DATA_W    = 16,
  parameter int CHANNEL   = 0,
  parameter int I2S_DELAY = 1
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  aud_dac_serializer_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DELAY, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lrck_q;
  logic              dacdat_q, dacdat_d;
  logic              finish_q, finish_d;
  logic              trunc_q, trunc_d;
  logic              lrck_edge, qual_edge;

  assign lrck_edge = (bus.i_daclrck != lrck_q);

  always_comb begin
    qual_edge = 1'b0;
    if (lrck_edge) begin
      if (CHANNEL == 2)      qual_edge = 1'b1;
      else if (CHANNEL == 1) qual_edge = bus.i_daclrck;
      else                   qual_edge = !bus.i_daclrck;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    dacdat_d = 1'b0;
    finish_d = 1'b0;
    trunc_d  = 1'b0;
    case (state_q)
      DELAY, SEND: begin
        // Any LR edge mid-word means the frame was shorter than the word: abort it.
        if (lrck_edge) begin
          trunc_d = 1'b1;
          state_d = IDLE;
        end else begin
          dacdat_d = sr_q[DATA_W-1];
          sr_d     = sr_q << 1;
          cnt_d    = cnt_q + 1'b1;
          if (state_q == SEND && cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
          else                                                state_d = SEND;
        end
      end
      DONE: begin
        finish_d = 1'b1;
        state_d  = IDLE;
      end
      default: ;
    endcase
    // A new word may start from any state; with no delay its MSB goes out on the edge cycle itself.
    if (qual_edge && bus.i_en) begin
      if (I2S_DELAY == 0) begin
        dacdat_d = bus.i_dac_data[DATA_W-1];
        sr_d     = bus.i_dac_data << 1;
        cnt_d    = CNT_W'(1);
        state_d  = SEND;
      end else begin
        dacdat_d = 1'b0;
        sr_d     = bus.i_dac_data;
        cnt_d    = '0;
        state_d  = DELAY;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    lrck_q <= bus.i_daclrck;
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      dacdat_q <= 1'b0;
      finish_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      dacdat_q <= dacdat_d;
      finish_q <= finish_d;
      trunc_q  <= trunc_d;
    end
  end

  assign bus.o_aud_dacdat  = dacdat_q;
  assign bus.o_sent_finish = finish_q;
  assign bus.o_truncated   = trunc_q;
  assign bus.o_busy        = (state_q == DELAY) || (state_q == SEND);
endmodule

// File: tb/tb_aud_dac_serializer.sv
// Bench for aud_dac_serializer: three configurations share one LRCK/data stream, each with its own scoreboard.
module tb_aud_dac_serializer;
  localparam int DW = 16;

  typedef struct {
    bit              is_fin;
    int              cyc;
    logic [DW-1:0]   word;
    int              nb;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          lrck;
  logic          lv;
  logic [DW-1:0] din;
  logic [2:0]    dacdat, fin, busy, trunc;
  int            cyc = 0;
  int            vecs = 0;
  int            errors = 0;
  exp_t          exp_q [3][$];
  logic [63:0]   hist [3] = '{default: '0};
  logic [7:0]    bh [3] = '{default: '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst0: CHANNEL=0 I2S; inst1: CHANNEL=2 I2S; inst2: CHANNEL=0 left-justified
  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    aud_dac_serializer_if #(.DATA_W(DW)) bus ();
    assign bus.i_en       = en;
    assign bus.i_daclrck  = lrck;
    assign bus.i_dac_data = din;
    assign dacdat[g]      = bus.o_aud_dacdat;
    assign fin[g]         = bus.o_sent_finish;
    assign busy[g]        = bus.o_busy;
    assign trunc[g]       = bus.o_truncated;
    aud_dac_serializer #(
      .DATA_W(DW), .CHANNEL(g == 1 ? 2 : 0), .I2S_DELAY(g == 2 ? 0 : 1)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );
  end

  function automatic int dl_of(int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic bit qualifies(int k, logic lvl);
    if (k == 1) return 1'b1;
    return (lvl == 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, string sig, int k, logic got);
    vecs++;
    if (got !== 1'b0) begin
      errors++;
      $display("FAIL %s_%s inst%0d: got %b, expected 0", tag, sig, k, got);
    end
  endtask

  task automatic chk_zero(string tag);
    for (int k = 0; k < 3; k++) begin
      chk1(tag, "dacdat", k, dacdat[k]);
      chk1(tag, "sent_finish", k, fin[k]);
      chk1(tag, "busy", k, busy[k]);
      chk1(tag, "truncated", k, trunc[k]);
    end
  endtask

  // One LRCK half-period: toggle LRCK, present data, queue each instance's expected outcome.
  task automatic frame(input int len, input logic [DW-1:0] data, input logic en_v, input int drop);
    int   n;
    exp_t e;
    lv   = ~lv;
    lrck = lv;
    din  = data;
    en   = en_v;
    n    = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (en_v && qualifies(k, lv)) begin
        e.word = data;
        if (len <= dl_of(k) + DW - 1) begin
          e.is_fin = 1'b0;
          e.cyc    = n + len;
          e.nb     = len - dl_of(k);
        end else begin
          e.is_fin = 1'b1;
          e.cyc    = n + dl_of(k) + DW;
          e.nb     = DW;
        end
        exp_q[k].push_back(e);
      end
    end
    for (int t = 1; t <= len; t++) begin
      tick();
      if (t == 1) din = ~data;
      if (t == drop) en = 1'b0;
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t          e;
    logic [DW-1:0] got_w, mask;
    for (int k = 0; k < 3; k++) begin
      hist[k] = {hist[k][62:0], dacdat[k]};
      bh[k]   = {bh[k][6:0], busy[k]};
      if (rst_n === 1'b1) begin
        vecs++;
        if (dacdat[k] === 1'b1 && bh[k][0] !== 1'b1 && bh[k][1] !== 1'b1) begin
          errors++;
          $display("FAIL idle_dacdat inst%0d cyc %0d: got 1, expected 0", k, cyc);
        end
      end
      if (fin[k] === 1'b1 || trunc[k] === 1'b1) begin
        vecs++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_event inst%0d cyc %0d: got fin=%b trunc=%b, expected none",
                   k, cyc, fin[k], trunc[k]);
        end else begin
          e = exp_q[k].pop_front();
          if ({fin[k], trunc[k]} !== {e.is_fin, !e.is_fin}) begin
            errors++;
            $display("FAIL event_kind inst%0d cyc %0d: got fin=%b trunc=%b, expected fin=%b",
                     k, cyc, fin[k], trunc[k], e.is_fin);
          end
          vecs++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL event_cycle inst%0d: got %0d, expected %0d", k, cyc, e.cyc);
          end
          got_w = '0;
          mask  = '0;
          for (int i = 0; i < e.nb; i++) begin
            got_w[DW-1-i] = hist[k][e.nb-i];
            mask[DW-1-i]  = 1'b1;
          end
          vecs++;
          if (got_w !== (e.word & mask)) begin
            errors++;
            $display("FAIL serial_word inst%0d cyc %0d: got %h, expected %h (%0d bits)",
                     k, cyc, got_w, e.word & mask, e.nb);
          end
          if (dl_of(k) == 1) begin
            vecs++;
            if (hist[k][e.nb+1] !== 1'b0) begin
              errors++;
              $display("FAIL lead_zero inst%0d cyc %0d: got %b, expected 0", k, cyc, hist[k][e.nb+1]);
            end
          end
          if (e.is_fin) begin
            vecs++;
            if (bh[k][2:1] !== 2'b10) begin
              errors++;
              $display("FAIL busy_profile inst%0d cyc %0d: got %b, expected 10", k, cyc, bh[k][2:1]);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    lrck  = 1'b0;
    lv    = 1'b0;
    din   = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    repeat (4) frame(32, 16'hF0CF, 1'b1, 0);
    repeat (4) frame(32, 16'h9C58, 1'b1, 0);
    repeat (6) frame(32, 16'hFFFF, 1'b0, 0);
    frame(32, 16'h3C96, 1'b1, 0);
    frame(32, 16'h3C96, 1'b1, 6);
    frame(32, 16'h3C96, 1'b1, 0);
    repeat (6) frame(10, 16'h6A4C, 1'b1, 0);
    frame(32, 16'h6A4C, 1'b1, 0);
    repeat (4) frame(17, 16'h5A3C, 1'b1, 0);
    repeat (2) frame(16, 16'hC3A5, 1'b1, 0);
    frame(32, 16'h9C58, 1'b1, 0);

    // Reset lands on bit 8 of a left-frame word; LRCK rises while reset is held.
    lv   = 1'b0;
    lrck = 1'b0;
    din  = 16'h83C1;
    en   = 1'b1;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    chk_zero("mid_reset");
    lv   = 1'b1;
    lrck = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (30) tick();

    repeat (3) frame(32, 16'h6A4C, 1'b1, 0);
    repeat (40) tick();

    for (int k = 0; k < 3; k++) begin
      while (exp_q[k].size() != 0) begin
        exp_t e;
        e = exp_q[k].pop_front();
        vecs++;
        errors++;
        $display("FAIL missing_event inst%0d: got none, expected fin=%b at cyc %0d", k, e.is_fin, e.cyc);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errors);
    $finish;
  end
endmodule

// File: doc/aud_dac_serializer.md
Name: aud_dac_serializer

Overview:
- Downstream consumer of AudDSP. Takes the parallel 16-bit sample on o_dac_data while o_player_en is high and shifts it MSB-first onto the WM8731 DACDAT pin.
- Alignment is I2S, relative to the codec's DACLRCK.
- Returns a one-cycle i_sent_finish pulse to AudDSP after each complete word.
- Runs on the codec bit-clock domain; one clock, no CDC inside the block.

Parameters:
- DATA_W, 16, sample width in bits (4..32).
- CHANNEL, 0, 0 = left frames only (DACLRCK low); 1 = right frames only (DACLRCK high); 2 = both frames.
- I2S_DELAY, 1, clocks between the DACLRCK edge and the MSB (0 = left-justified, 1 = I2S).

Ports:
- i_clk  in  1  bit clock (BCLK-rate); all logic on posedge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_en  in  1  player enable (AudDSP o_player_en).
- i_daclrck  in  1  codec LR clock; sampled as data on i_clk.
- i_dac_data  in  DATA_W  sample to play (AudDSP o_dac_data).
- o_aud_dacdat  out  1  serial data to codec.
- o_sent_finish  out  1  one-cycle pulse: word fully shifted.
- o_busy  out  1  high in DELAY/SEND.
- o_truncated  out  1  one-cycle pulse: word aborted by an early LRCK edge.

Behaviour:
- Reset (i_rst_n low at a posedge): state=IDLE; o_aud_dacdat=0, o_sent_finish=0, o_busy=0, o_truncated=0; shift reg=0; bit counter=0; lrck_q=i_daclrck (no false edge after reset). Applies mid-word: output drops to 0 at the next posedge, no sent_finish.
- Edge detect: edge = (i_daclrck != lrck_q); lrck_q <= i_daclrck every cycle.
- An edge is qualifying when:
  - CHANNEL=0 and new i_daclrck=0;
  - CHANNEL=1 and new i_daclrck=1;
  - CHANNEL=2 on any edge.
- Posedge N is the cycle at which a qualifying edge is seen.
- FSM states: IDLE, DELAY, SEND, DONE.
- IDLE:
  - On a qualifying edge with i_en=1: latch i_dac_data into the shift reg; cnt=0.
  - Go to DELAY if I2S_DELAY=1, else SEND.
  - Otherwise stay; o_aud_dacdat=0.
- DELAY: one cycle; o_aud_dacdat=0; go to SEND.
- SEND:
  - o_aud_dacdat is registered. Bit k (k=0 is the MSB) is driven from posedge N+I2S_DELAY+k to posedge N+I2S_DELAY+k+1.
  - Shift left each cycle; cnt increments.
  - After cnt reaches DATA_W-1, go to DONE.
- DONE:
  - o_sent_finish=1 for exactly one cycle, from posedge N+I2S_DELAY+DATA_W.
  - o_aud_dacdat=0; go to IDLE.
  - A qualifying edge seen in the same cycle is honoured: latch and go to DELAY/SEND directly.
- i_en falls during DELAY/SEND: the current word completes normally, including sent_finish; no new word starts while i_en=0.
- i_dac_data changing after the latch has no effect on the word in flight.
- Any DACLRCK edge (qualifying or not) seen in DELAY or SEND:
  - Abort the word; o_aud_dacdat=0 from the next posedge; o_truncated=1 for one cycle; no sent_finish.
  - If the edge qualifies and i_en=1: latch the new word (restart at DELAY/SEND); else go to IDLE.
- o_busy=1 exactly while state is DELAY or SEND.
- Frames of length ≥ DATA_W+I2S_DELAY+1 clocks never truncate.
- Bits beyond DATA_W within a frame are 0.

Test Plan:
- DATA_W=16, I2S_DELAY=1, CHANNEL=0; LRCK period 64 clk (32 low/32 high); i_en=1; i_dac_data=16'hF0CF. Required:
  - DACDAT=0 for 1 clk after the LRCK fall, then bits 1111_0000_1100_1111 on 16 consecutive clks, then 0 for the rest of the frame and all of the right frame.
  - o_sent_finish pulse 17 clks after the fall-detect cycle.
- Same setup, CHANNEL=2, i_dac_data=16'h9C58: two words per LRCK period, each followed by one sent_finish (2 pulses/period); the right-frame word is identical.
- i_en=0 for 3 frames, then 1: no DACDAT activity and no sent_finish while disabled. i_en dropped at bit 5 of a word: the word still completes with 16 bits and a sent_finish.
- LRCK half-period shortened to 10 clk, CHANNEL=2: o_truncated pulses at the 11th clk of each word, no sent_finish, DACDAT restarts with the MSB after the new edge + 1 clk.
- i_rst_n=0 for 2 clks at bit 8 of word 16'h83C1: outputs 0 at the next posedge. After release, the first LRCK fall-edge detected restarts a clean word; no spurious edge occurs at reset release.
- I2S_DELAY=0, i_dac_data=16'h6A4C: MSB (0) is driven from the fall-detect posedge; sent_finish at +16 clks.
